// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, control-bundle width and control-bit indices for pipeline stages.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
  localparam int CTRL_W_DEF = 8;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_ALUOP_LSB = 4;
endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: saturating up-counter with synchronous clear and asynchronous active-low reset.
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: 2-entry skid-buffer pipeline register with flush and bubble control.
// Define PIPE_STAGE_PERF_CNT_EN to add saturating stall_cnt/flush_cnt outputs.
import pipe_pkg::*;
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              bubble
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);
  state_t state;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic acc, drn;
  assign in_ready = (state != SKID) && !bubble;
  assign out_valid = state != EMPTY;
  assign out_data = main_data;
  assign out_ctrl = main_ctrl;
  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;
  // main_ctrl is zeroed whenever the stage empties so a bubble never carries live control bits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
      main_ctrl <= '0;
    end else
      case (state)
        EMPTY: if (acc) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
          state <= FULL;
        end
        FULL: if (acc && drn) begin
          main_data <= in_data;
          main_ctrl <= in_ctrl;
        end else if (acc) begin
          skid_data <= in_data;
          skid_ctrl <= in_ctrl;
          state <= SKID;
        end else if (drn) begin
          main_ctrl <= '0;
          state <= EMPTY;
        end
        SKID: if (drn) begin
          main_data <= skid_data;
          main_ctrl <= skid_ctrl;
          state <= FULL;
        end
        default: state <= EMPTY;
      endcase
`ifdef PIPE_STAGE_PERF_CNT_EN
  pipe_sat_cnt #(.W(16)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(in_valid && !in_ready), .clr(1'b0), .cnt(stall_cnt)
  );
  pipe_sat_cnt #(.W(16)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .inc(flush), .clr(1'b0), .cnt(flush_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed vector table plus hand sequences for reset, skid, flush and bubble cases.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, flush, bubble;
  logic [31:0] in_data, out_data;
  logic [7:0] in_ctrl, out_ctrl;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .bubble(bubble)
`ifdef PIPE_STAGE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic iv;
    logic [31:0] d;
    logic [7:0] c;
    logic ordy, fl, bb;
    logic eov, eir;
    logic [31:0] eod;
    logic [7:0] eoc;
  } vec_t;
  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] c,
                       input logic ordy, input logic fl, input logic bb);
    in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; bubble = bb;
  endtask

  initial begin
    // each row: inputs for one edge, then outputs seen half a cycle after that edge
    tbl[0]  = '{1'b1, 32'hAA, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAA, 8'h11};
    tbl[1]  = '{1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAA, 8'h00};
    tbl[2]  = '{1'b1, 32'h1,  8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1,  8'h01};
    tbl[3]  = '{1'b1, 32'h2,  8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1,  8'h01};
    tbl[4]  = '{1'b1, 32'h3,  8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1,  8'h01};
    tbl[5]  = '{1'b1, 32'h3,  8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2,  8'h02};
    tbl[6]  = '{1'b1, 32'h3,  8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3,  8'h03};
    tbl[7]  = '{1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3,  8'h00};
    tbl[8]  = '{1'b1, 32'h4,  8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4,  8'h04};
    tbl[9]  = '{1'b1, 32'h5,  8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4,  8'h04};
    tbl[10] = '{1'b1, 32'h6,  8'h06, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4,  8'h00};
    tbl[11] = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4,  8'h00};
    tbl[12] = '{1'b1, 32'h7,  8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7,  8'h07};
    tbl[13] = '{1'b1, 32'h8,  8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7,  8'h00};
    tbl[14] = '{1'b1, 32'h8,  8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7,  8'h00};
    tbl[15] = '{1'b1, 32'h9,  8'h09, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h9,  8'h09};
    tbl[16] = '{1'b1, 32'hA,  8'h0A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h9,  8'h00};
    tbl[17] = '{1'b0, 32'h0,  8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h9,  8'h00};
    tbl[18] = '{1'b1, 32'hB,  8'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hB,  8'h0B};
    tbl[19] = '{1'b1, 32'hC,  8'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB,  8'h0B};
    tbl[20] = '{1'b1, 32'hD,  8'h0D, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC,  8'h0C};
    tbl[21] = '{1'b0, 32'h0,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC,  8'h00};

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_ctrl", {24'b0, out_ctrl}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl, tbl[i].bb);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].eov});
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].eir});
      chk($sformatf("v%0d_out_data", i), out_data, tbl[i].eod);
      chk($sformatf("v%0d_out_ctrl", i), {24'b0, out_ctrl}, {24'b0, tbl[i].eoc});
    end
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("flush_cnt_two", {16'b0, flush_cnt}, 32'h2);
`endif

    drive(1'b1, 32'h21, 8'h21, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h22, 8'h22, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_skid_in_ready", {31'b0, in_ready}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("midrst_out_data", out_data, 32'h0);
    chk("midrst_out_ctrl", {24'b0, out_ctrl}, 32'h0);
`ifdef PIPE_STAGE_PERF_CNT_EN
    chk("midrst_flush_cnt", {16'b0, flush_cnt}, 32'h0);
    chk("midrst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
`endif
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h33, 8'h33, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("postrst_out_valid", {31'b0, out_valid}, 32'h1);
    chk("postrst_out_data", out_data, 32'h33);
    chk("postrst_out_ctrl", {24'b0, out_ctrl}, 32'h33);
    drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("postrst_drain_valid", {31'b0, out_valid}, 32'h0);
    chk("postrst_drain_ctrl", {24'b0, out_ctrl}, 32'h0);

`ifdef PIPE_STAGE_PERF_CNT_EN
    drive(1'b1, 32'h44, 8'h44, 1'b0, 1'b0, 1'b0);
    repeat (70000) @(negedge clk);
    chk("stall_cnt_sat", {16'b0, stall_cnt}, 32'hFFFF);
    repeat (5) @(negedge clk);
    chk("stall_cnt_hold", {16'b0, stall_cnt}, 32'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    chk("rst_flush_cnt", {16'b0, flush_cnt}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
